// File: rtl/nf10_axil_master.sv
// Single-outstanding AXI4-Lite master: turns a command/response stream into AXI4-Lite
// write and read transactions, with a per-handshake timeout that aborts a hung slave.
module nf10_axil_master #(
    parameter int C_ADDR_WIDTH     = 32,
    parameter int C_DATA_WIDTH     = 32,
    parameter int C_TIMEOUT_CYCLES = 1024
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rnw,
    input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam int CNT_W = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((C_TIMEOUT_CYCLES > 0) ? C_TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

    state_t           state;
    logic             aw_done;
    logic             w_done;
    logic [CNT_W-1:0] tmo_cnt;
    logic             aw_fin;
    logic             w_fin;
    logic             wait_st;
    logic             done_now;
    logic             abort;

    // AW and W may complete in either order; a done flag remembers the earlier one.
    assign aw_fin  = aw_done | (M_AXI_AWVALID & M_AXI_AWREADY);
    assign w_fin   = w_done  | (M_AXI_WVALID  & M_AXI_WREADY);
    assign wait_st = (state == WR_AW_W) || (state == WR_B) || (state == RD_AR) || (state == RD_R);

    always_comb begin
        done_now = 1'b0;
        case (state)
            WR_AW_W: done_now = aw_fin & w_fin;
            WR_B:    done_now = M_AXI_BVALID & M_AXI_BREADY;
            RD_AR:   done_now = M_AXI_ARVALID & M_AXI_ARREADY;
            RD_R:    done_now = M_AXI_RVALID & M_AXI_RREADY;
            default: done_now = 1'b0;
        endcase
    end

    // A handshake landing on the last allowed cycle still completes normally.
    assign abort = (C_TIMEOUT_CYCLES != 0) && wait_st && !done_now && (tmo_cnt == TMO_LAST);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            rsp_timeout   <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            tmo_cnt       <= '0;
        end else if (abort) begin
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_timeout   <= 1'b1;
            rsp_resp      <= 2'b10;
            rsp_rdata     <= '0;
            tmo_cnt       <= '0;
            state         <= RSP;
        end else begin
            tmo_cnt <= (wait_st && !done_now) ? tmo_cnt + CNT_W'(1) : '0;
            case (state)
                IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready <= 1'b0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (cmd_rnw) begin
                            M_AXI_ARADDR  <= cmd_addr;
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RD_AR;
                        end else begin
                            M_AXI_AWADDR  <= cmd_addr;
                            M_AXI_WDATA   <= cmd_wdata;
                            M_AXI_WSTRB   <= cmd_wstrb;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WR_AW_W;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WR_AW_W: begin
                    aw_done <= aw_fin;
                    w_done  <= w_fin;
                    if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WR_B;
                    end
                end
                WR_B: begin
                    if (M_AXI_BVALID && M_AXI_BREADY) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_rdata    <= '0;
                        rsp_timeout  <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end
                RD_AR: begin
                    if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_R;
                    end
                end
                RD_R: begin
                    if (M_AXI_RVALID && M_AXI_RREADY) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_timeout  <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nf10_axil_master.sv
// Bench for nf10_axil_master: table of transactions against a delay-configurable slave
// model, plus hand-written reset sequences.
module tb_nf10_axil_master;

    localparam int N = 1000;  // "never" delay for the slave model

    logic        aclk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    int total = 0;
    int passed = 0;

    nf10_axil_master #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(32), .C_TIMEOUT_CYCLES(16)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        string       name;
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
        logic [1:0]  sresp;
        logic [31:0] sdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic        exp_to;
        int          exp_rsp, exp_awv, exp_wv, exp_bry, exp_bry_first, exp_arv, exp_rry;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic slave_idle();
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    endtask

    // Entered and left at a negedge; cycle 0 is the cycle in which the command is accepted.
    task automatic run_vec(input vec_t v);
        int aw_w = 0, w_w = 0, b_w = 0, ar_w = 0, r_w = 0, rsp_w = 0;
        bit aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, done = 0;
        int awv_n = 0, wv_n = 0, bry_n = 0, arv_n = 0, rry_n = 0;
        int bry_first = -1, rsp_first = -1, unstable = 0, cr_bad = 0;
        logic [31:0] r_d = '0;
        logic [1:0]  r_r = '0;
        logic        r_t = 1'b0;
        cmd_valid = 1'b1; cmd_rnw = v.rnw; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        chk({v.name, " cmd_ready_idle"}, cmd_ready, 1);
        for (int k = 1; k <= 200 && !done; k++) begin
            @(negedge aclk);
            // junk command held outside IDLE must be ignored
            cmd_rnw = ~v.rnw; cmd_addr = 32'hFFFF_FFF0; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hA;
            if (cmd_ready) cr_bad++;
            M_AXI_BVALID = 1'b0;
            if (aw_hs && w_hs && !b_hs) begin
                if (b_w >= v.b_dly) begin
                    M_AXI_BVALID = 1'b1; M_AXI_BRESP = v.sresp;
                    if (M_AXI_BREADY) b_hs = 1;
                end else b_w++;
            end
            if (M_AXI_BREADY) begin
                bry_n++;
                if (bry_first < 0) bry_first = k;
            end
            M_AXI_AWREADY = 1'b0;
            if (M_AXI_AWVALID) begin
                awv_n++;
                if (M_AXI_AWADDR !== v.addr) unstable++;
                if (aw_w >= v.aw_dly) begin M_AXI_AWREADY = 1'b1; aw_hs = 1; end
                else aw_w++;
            end
            M_AXI_WREADY = 1'b0;
            if (M_AXI_WVALID) begin
                wv_n++;
                if (M_AXI_WDATA !== v.wdata || M_AXI_WSTRB !== v.wstrb) unstable++;
                if (w_w >= v.w_dly) begin M_AXI_WREADY = 1'b1; w_hs = 1; end
                else w_w++;
            end
            M_AXI_RVALID = 1'b0;
            if (ar_hs && !r_hs) begin
                if (r_w >= v.r_dly) begin
                    M_AXI_RVALID = 1'b1; M_AXI_RDATA = v.sdata; M_AXI_RRESP = v.sresp;
                    if (M_AXI_RREADY) r_hs = 1;
                end else r_w++;
            end
            if (M_AXI_RREADY) rry_n++;
            M_AXI_ARREADY = 1'b0;
            if (M_AXI_ARVALID) begin
                arv_n++;
                if (M_AXI_ARADDR !== v.addr) unstable++;
                if (ar_w >= v.ar_dly) begin M_AXI_ARREADY = 1'b1; ar_hs = 1; end
                else ar_w++;
            end
            rsp_ready = 1'b0;
            if (rsp_valid) begin
                if (rsp_first < 0) begin
                    rsp_first = k; r_d = rsp_rdata; r_r = rsp_resp; r_t = rsp_timeout;
                end else if ({rsp_rdata, rsp_resp, rsp_timeout} !== {r_d, r_r, r_t}) unstable++;
                if (rsp_w >= v.rsp_dly) begin rsp_ready = 1'b1; done = 1; cmd_valid = 1'b0; end
                else rsp_w++;
            end else if (rsp_first >= 0) unstable++;
        end
        cmd_valid = 1'b0;
        chk({v.name, " completed_within_budget"}, done, 1);
        chk({v.name, " rsp_rdata"}, r_d, v.exp_rdata);
        chk({v.name, " rsp_resp"}, r_r, v.exp_resp);
        chk({v.name, " rsp_timeout"}, r_t, v.exp_to);
        chk({v.name, " rsp_valid_cycle"}, rsp_first, v.exp_rsp);
        chk({v.name, " awvalid_cycles"}, awv_n, v.exp_awv);
        chk({v.name, " wvalid_cycles"}, wv_n, v.exp_wv);
        chk({v.name, " bready_cycles"}, bry_n, v.exp_bry);
        chk({v.name, " bready_first_cycle"}, bry_first, v.exp_bry_first);
        chk({v.name, " arvalid_cycles"}, arv_n, v.exp_arv);
        chk({v.name, " rready_cycles"}, rry_n, v.exp_rry);
        chk({v.name, " stability_violations"}, unstable, 0);
        chk({v.name, " cmd_ready_busy"}, cr_bad, 0);
        @(negedge aclk);
        rsp_ready = 1'b0;
        slave_idle();
        chk({v.name, " rsp_valid_after"}, rsp_valid, 0);
        chk({v.name, " cmd_ready_after"}, cmd_ready, 1);
    endtask

    initial begin
        //          name            rnw addr          wdata         strb aw w  b  ar r  rsp sresp  sdata         exp_rdata     resp  to rsp awv wv bry bf arv rry
        vecs[0] = '{"wr_basic",     0, 32'h7760_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, N, N, 0, 2'b00, 32'h0,        32'h0,        2'b00, 0, 3,  1, 1, 1,  2,  0,  0};
        vecs[1] = '{"rd_delayed",   1, 32'h7760_0004, 32'h0,        4'h0, N, N, N, 3, 2, 0, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 0, 8,  0, 0, 0, -1,  4,  3};
        vecs[2] = '{"wr_skew",      0, 32'h7760_0008, 32'h1234_5678, 4'h3, 4, 0, 0, N, N, 0, 2'b00, 32'h0,        32'h0,        2'b00, 0, 7,  5, 1, 1,  6,  0,  0};
        vecs[3] = '{"wr_slverr_bp", 0, 32'h7760_0010, 32'hA5A5_5A5A, 4'hF, 0, 0, 1, N, N, 6, 2'b10, 32'h0,        32'h0,        2'b10, 0, 4,  1, 1, 2,  2,  0,  0};
        vecs[4] = '{"rd_decerr",    1, 32'h7761_0000, 32'h0,        4'h0, N, N, N, 0, 0, 0, 2'b11, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'b11, 0, 3,  0, 0, 0, -1,  1,  1};
        vecs[5] = '{"rd_timeout",   1, 32'h7760_0020, 32'h0,        4'h0, N, N, N, N, N, 0, 2'b00, 32'h1111_1111, 32'h0,        2'b10, 1, 17, 0, 0, 0, -1, 16,  0};
        vecs[6] = '{"rd_after_to",  1, 32'h7760_000C, 32'h0,        4'h0, N, N, N, 0, 0, 0, 2'b00, 32'h0BAD_F00D, 32'h0BAD_F00D, 2'b00, 0, 3,  0, 0, 0, -1,  1,  1};
        vecs[7] = '{"wr_b_timeout", 0, 32'h7760_0014, 32'h0000_00FF, 4'h1, 0, 0, N, N, N, 0, 2'b00, 32'h0,        32'h0,        2'b10, 1, 18, 1, 1, 16, 2,  0,  0};
        vecs[8] = '{"wr_w_late",    0, 32'h7760_0018, 32'h0F0F_0F0F, 4'h5, 0, 2, 0, N, N, 0, 2'b00, 32'h0,        32'h0,        2'b00, 0, 5,  1, 3, 1,  4,  0,  0};
        vecs[9] = '{"wr_both_late", 0, 32'h7760_001C, 32'h8000_0001, 4'hF, 2, 2, 2, N, N, 1, 2'b01, 32'h0,        32'h0,        2'b01, 0, 7,  3, 3, 3,  4,  0,  0};

        areset = 1'b1;
        cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        slave_idle();
        repeat (2) @(negedge aclk);
        chk("reset cmd_ready", cmd_ready, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset axi_valid_ready", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        chk("reset rsp_fields", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
        chk("reset axi_addr_data", {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB}, 0);
        areset = 1'b0;
        chk("release cmd_ready_low", cmd_ready, 0);
        @(negedge aclk);
        chk("release cmd_ready_high", cmd_ready, 1);

        // reset asserted mid-write with a stalled slave
        cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 32'h7760_0004; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
        @(negedge aclk);
        cmd_valid = 1'b0;
        chk("midwr valids_up", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
        @(negedge aclk);
        #2 areset = 1'b1;
        #1;
        chk("midwr async_clear", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, cmd_ready}, 0);
        repeat (5) @(negedge aclk);
        areset = 1'b0;
        chk("midwr cmd_ready_at_release", cmd_ready, 0);
        @(negedge aclk);
        chk("midwr cmd_ready_after", cmd_ready, 1);
        chk("midwr no_response", rsp_valid, 0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nf10_axil_master.md
Name: nf10_axil_master

Overview:
- Single-outstanding AXI4-Lite master (initiator) that converts a simple command/response stream into AXI4-Lite write and read transactions.
- Programs and polls register slaves on the S_AXI port of the generator/checker cores, e.g. the block at 0x77600000–0x7760FFFF, from a test sequencer or host bridge.
- Drives the AW/W/B/AR/R channels. Returns the read data or write status and a timeout flag per command.

Parameters:
- C_ADDR_WIDTH, 32, AXI address width.
- C_DATA_WIDTH, 32, AXI data width; C_DATA_WIDTH/8 strobe bits.
- C_TIMEOUT_CYCLES, 1024, maximum wait per channel handshake before abort; 0 disables the timeout.

Ports:
- aclk  in  1  clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_rnw  in  1  1=read, 0=write.
- cmd_addr  in  C_ADDR_WIDTH  byte address.
- cmd_wdata  in  C_DATA_WIDTH  write data.
- cmd_wstrb  in  C_DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  C_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  transaction aborted by timeout.
- M_AXI_AWADDR out C_ADDR_WIDTH; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_WDATA out C_DATA_WIDTH; M_AXI_WSTRB out C_DATA_WIDTH/8; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out C_ADDR_WIDTH; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in C_DATA_WIDTH; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All valid/ready outputs 0, including cmd_ready. All data, address, rsp_* outputs 0. Timeout counter 0.
- All outputs are registered. States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, capture addr/wdata/wstrb/rnw and set cmd_ready=0 next cycle.
  - Write: go to WR_AW_W with AWVALID=WVALID=1 on the next cycle.
  - Read: go to RD_AR with ARVALID=1 on the next cycle.
- WR_AW_W:
  - AW and W are tracked independently with done flags.
  - Each valid drops the cycle after its own handshake; AW and W may complete in any order or in the same cycle.
  - When both are done, go to WR_B with BREADY=1.
- WR_B: on BVALID&BREADY, latch BRESP, drop BREADY, go to RSP.
- RD_AR: on ARREADY, drop ARVALID, go to RD_R with RREADY=1.
- RD_R: on RVALID&RREADY, latch RDATA/RRESP, drop RREADY, go to RSP.
- RSP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - Then rsp_valid=0, go to IDLE with cmd_ready=1 the following cycle.
  - Minimum command-to-command spacing is therefore 1 cycle after the response is consumed.
- Latency with an always-ready slave:
  - Write: cmd accept at cycle 0, AW/W handshake cycle 1, B handshake cycle 2, rsp_valid cycle 3.
  - Read: the same, with AR in cycle 1 and R in cycle 2.
- AXI rules:
  - A valid never drops before its handshake, except on timeout.
  - Address and data are stable while valid.
  - AWPROT/ARPROT are not driven (slave ties them to 0).
- Timeout:
  - The counter resets on each state entry and increments each cycle in WR_AW_W, WR_B, RD_AR and RD_R.
  - Reaching C_TIMEOUT_CYCLES forces all AXI valid/ready outputs to 0 and goes to RSP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
  - The slave must be reset after a timeout; this is a documented protocol violation.
  - rsp_timeout is 0 for every normal completion.
- Response codes: SLVERR/DECERR from the slave are passed through unchanged with rsp_timeout=0.
- Reset mid-transaction: the command is aborted, no response is issued, and all outputs return to reset values immediately.
- cmd_* inputs are ignored outside IDLE.

Test Plan:
- Reset then idle: assert areset for 5 cycles mid-write -> all M_AXI valids, BREADY/RREADY and rsp_valid go to 0 asynchronously; cmd_ready=1 one cycle after release.
- Write 0xDEADBEEF to 0x77600004, wstrb 0xF, slave always ready, BRESP=00 -> AWVALID/WVALID high cycle 1 only, BREADY cycle 2, rsp_valid cycle 3, rsp_resp=00, rsp_rdata=0.
- Read 0x77600004 with slave returning 0xDEADBEEF, RRESP=00, after ARREADY delayed 3 cycles and RVALID delayed 2 cycles -> ARADDR stable while ARVALID high; rsp_rdata=0xDEADBEEF, rsp_timeout=0.
- Skewed write: WREADY asserted 4 cycles before AWREADY -> WVALID drops after its handshake, AWVALID holds; BREADY rises only after the AW handshake.
- Back-pressure and error: slave returns BRESP=10; hold rsp_ready=0 for 6 cycles -> rsp_valid and rsp_resp=10 stable throughout, cmd_ready=0 until the response is consumed.
- Timeout: C_TIMEOUT_CYCLES=16, ARREADY never asserted -> ARVALID drops after 16 cycles in RD_AR; rsp_timeout=1, rsp_resp=10, rsp_rdata=0; the next command is accepted normally.
